// File: rtl/cpu_boot_streamer_pkg.sv
// Shared definitions for the CPU boot image streamer: FSM states, error codes
// and cpu bus geometry.
package cpu_boot_streamer_pkg;

    localparam int unsigned BUS_ADDR_W = 32;
    localparam int unsigned BUS_DATA_W = 32;
    localparam int unsigned BUS_MASK_W = 4;
    localparam int unsigned ERR_W      = 2;
    localparam int unsigned LANE_W     = 2;

    localparam logic [ERR_W-1:0] ERR_NONE    = 2'd0;
    localparam logic [ERR_W-1:0] ERR_LENGTH  = 2'd1;
    localparam logic [ERR_W-1:0] ERR_TIMEOUT = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN,
        ST_DATA,
        ST_WRITE,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } boot_state_t;

    // Number of enabled byte lanes in a write mask.
    function automatic logic [2:0] mask_popcount(input logic [BUS_MASK_W-1:0] mask);
        logic [2:0] n;
        n = 3'd0;
        for (int unsigned i = 0; i < BUS_MASK_W; i++) begin
            n = n + 3'(mask[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/cpu_boot_word_packer.sv
// Packs a byte stream into little-endian 32-bit words with per-lane byte enables.
module cpu_boot_word_packer
    import cpu_boot_streamer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  byte_stb,
    input  logic                  last,
    input  logic [7:0]            byte_data,
    output logic [BUS_DATA_W-1:0] wdata,
    output logic [BUS_MASK_W-1:0] wmask,
    output logic                  word_fill_c
);

    logic [LANE_W-1:0]     lane_q, lane_d;
    logic [BUS_DATA_W-1:0] wdata_q, wdata_d;
    logic [BUS_MASK_W-1:0] wmask_q, wmask_d;

    // A strobed byte completes the word when it lands in the top lane or is the image's last.
    assign word_fill_c = (lane_q == LANE_W'(3)) || last;

    always_comb begin
        lane_d  = lane_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        if (clear) begin
            lane_d  = '0;
            wdata_d = '0;
            wmask_d = '0;
        end else if (byte_stb) begin
            wdata_d[{lane_q, 3'b000} +: 8] = byte_data;
            wmask_d[lane_q]                = 1'b1;
            lane_d                         = lane_q + LANE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lane_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
        end else begin
            lane_q  <= lane_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
        end
    end

    assign wdata = wdata_q;
    assign wmask = wmask_q;

endmodule

// File: rtl/cpu_boot_streamer.sv
// Loads a length-prefixed byte stream into CPU memory through single-outstanding
// cpu bus word writes; flags completion, over-length images and ack timeouts.
module cpu_boot_streamer
    import cpu_boot_streamer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h0000_0000,
    parameter logic [31:0] MAX_LENGTH   = 32'h0001_0000,
    parameter int unsigned ACK_TIMEOUT  = 1024
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    output logic        bus_request,
    output logic [31:0] bus_address,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wmask,
    input  logic        bus_ack,
    output logic        busy,
    output logic        done,
    output logic [1:0]  error,
    output logic [31:0] bytes_written
);

    localparam int unsigned CNT_W = 32;

    boot_state_t state_q, state_d;

    logic [CNT_W-1:0]      length_q, length_d;
    logic [1:0]            len_idx_q, len_idx_d;
    logic [CNT_W-1:0]      rcvd_q, rcvd_d;
    logic [BUS_ADDR_W-1:0] ptr_q, ptr_d;
    logic [CNT_W-1:0]      tmo_q, tmo_d;
    logic [CNT_W-1:0]      bytes_written_q, bytes_written_d;
    logic [BUS_ADDR_W-1:0] bus_address_q, bus_address_d;
    logic                  bus_request_q, bus_request_d;
    logic                  rx_ready_q, rx_ready_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [ERR_W-1:0]      error_q, error_d;

    logic                  pk_clear_c;
    logic                  pk_stb_c;
    logic                  pk_word_fill_c;
    logic                  last_c;
    logic [CNT_W-1:0]      len_shift_c;
    logic [BUS_DATA_W-1:0] pk_wdata;
    logic [BUS_MASK_W-1:0] pk_wmask;

    // Length arrives LSB first, so each new byte shifts in from the top.
    assign len_shift_c = {rx_data, length_q[CNT_W-1:8]};
    assign last_c      = (rcvd_q == length_q - CNT_W'(1));

    cpu_boot_word_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (pk_clear_c),
        .byte_stb    (pk_stb_c),
        .last        (last_c),
        .byte_data   (rx_data),
        .wdata       (pk_wdata),
        .wmask       (pk_wmask),
        .word_fill_c (pk_word_fill_c)
    );

    // Next-state and registered-output logic; abort overrides every state.
    always_comb begin
        state_d         = state_q;
        length_d        = length_q;
        len_idx_d       = len_idx_q;
        rcvd_d          = rcvd_q;
        ptr_d           = ptr_q;
        tmo_d           = tmo_q;
        bytes_written_d = bytes_written_q;
        bus_address_d   = bus_address_q;
        done_d          = done_q;
        error_d         = error_q;
        pk_clear_c      = 1'b0;
        pk_stb_c        = 1'b0;

        if (abort) begin
            state_d    = ST_IDLE;
            pk_clear_c = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (start) begin
                        state_d         = ST_LEN;
                        done_d          = 1'b0;
                        error_d         = ERR_NONE;
                        bytes_written_d = '0;
                        length_d        = '0;
                        len_idx_d       = '0;
                        rcvd_d          = '0;
                        ptr_d           = BASE_ADDRESS;
                        pk_clear_c      = 1'b1;
                    end
                end
                ST_LEN: begin
                    if (rx_valid && rx_ready_q) begin
                        length_d  = len_shift_c;
                        len_idx_d = len_idx_q + 2'd1;
                        if (len_idx_q == 2'd3) begin
                            if (len_shift_c > MAX_LENGTH) begin
                                state_d = ST_ERROR;
                                error_d = ERR_LENGTH;
                            end else if (len_shift_c == '0) begin
                                state_d = ST_DONE;
                                done_d  = 1'b1;
                            end else begin
                                state_d = ST_DATA;
                            end
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid && rx_ready_q) begin
                        pk_stb_c = 1'b1;
                        rcvd_d   = rcvd_q + CNT_W'(1);
                        if (pk_word_fill_c) begin
                            state_d       = ST_WRITE;
                            bus_address_d = ptr_q;
                        end
                    end
                end
                ST_WRITE: begin
                    state_d = ST_WAIT_ACK;
                    tmo_d   = '0;
                end
                ST_WAIT_ACK: begin
                    if (bus_ack) begin
                        bytes_written_d = bytes_written_q + CNT_W'(mask_popcount(pk_wmask));
                        pk_clear_c      = 1'b1;
                        ptr_d           = ptr_q + BUS_ADDR_W'(4);
                        if (rcvd_q == length_q) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_DATA;
                        end
                    end else if (tmo_q == CNT_W'(ACK_TIMEOUT - 1)) begin
                        state_d = ST_ERROR;
                        error_d = ERR_TIMEOUT;
                    end else begin
                        tmo_d = tmo_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        rx_ready_d    = (state_d == ST_LEN) || (state_d == ST_DATA);
        busy_d        = rx_ready_d || (state_d == ST_WRITE) || (state_d == ST_WAIT_ACK);
        bus_request_d = (state_d == ST_WRITE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            length_q        <= '0;
            len_idx_q       <= '0;
            rcvd_q          <= '0;
            ptr_q           <= '0;
            tmo_q           <= '0;
            bytes_written_q <= '0;
            bus_address_q   <= '0;
            bus_request_q   <= 1'b0;
            rx_ready_q      <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= ERR_NONE;
        end else begin
            state_q         <= state_d;
            length_q        <= length_d;
            len_idx_q       <= len_idx_d;
            rcvd_q          <= rcvd_d;
            ptr_q           <= ptr_d;
            tmo_q           <= tmo_d;
            bytes_written_q <= bytes_written_d;
            bus_address_q   <= bus_address_d;
            bus_request_q   <= bus_request_d;
            rx_ready_q      <= rx_ready_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
        end
    end

    assign rx_ready      = rx_ready_q;
    assign bus_request   = bus_request_q;
    assign bus_address   = bus_address_q;
    assign bus_wdata     = pk_wdata;
    assign bus_wmask     = pk_wmask;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign bytes_written = bytes_written_q;

endmodule
